// File: rtl/io_irq_controller.sv
// Interrupt hub: per-channel edge capture, mask, fixed priority (channel 0 highest),
// latched vector and ack/EOI sequencing behind a 4-word register window.

module io_irq_chan (
  input  logic clock,
  input  logic reset,
  input  logic i_req,
  input  logic i_clr,
  output logic o_pending
);
  logic r_prev;
  logic r_pending;

  // A rise in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_prev    <= i_req;
      r_pending <= (r_pending & ~i_clr) | (i_req & ~r_prev);
    end
  end

  assign o_pending = r_pending;
endmodule

module io_irq_controller #(
  parameter int          NUM_CH    = 4,
  parameter int          CH_W      = 2,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq_req,
  input  logic              irq_ack,
  output logic              irq,
  output logic [CH_W-1:0]   vector,
  output logic              busy,
  input  logic [15:0]       waddr,
  input  logic [15:0]       wdata,
  input  logic              wenable,
  input  logic [15:0]       raddr,
  output logic [15:0]       rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t            r_state, w_state_n;
  logic              r_irq, w_irq_n;
  logic [CH_W-1:0]   r_vector, w_vector_n, w_low;
  logic [NUM_CH-1:0] r_mask;
  logic [15:0]       r_rdata, w_rdata_n;
  logic [NUM_CH-1:0] w_pending, w_elig, w_ack_clr, w_clr;
  logic [15:0]       w_woff, w_roff;
  logic              w_wr_hit, w_mask_we, w_w1c, w_eoi, w_busy;
  logic              w_unused;

  // Offsets wrap modulo 2^16, so a window near the top of the map still decodes.
  assign w_woff    = waddr - BASE_ADDR;
  assign w_roff    = raddr - BASE_ADDR;
  assign w_wr_hit  = wenable && (w_woff[15:2] == 14'd0);
  assign w_mask_we = w_wr_hit && (w_woff[1:0] == 2'd0);
  assign w_w1c     = w_wr_hit && (w_woff[1:0] == 2'd1);
  assign w_eoi     = w_wr_hit && (w_woff[1:0] == 2'd3);
  assign w_unused  = ^wdata;

  assign w_elig = w_pending & r_mask;
  assign w_busy = (r_state != S_IDLE);
  assign w_clr  = w_ack_clr | (w_w1c ? wdata[NUM_CH-1:0] : '0);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      io_irq_chan u_chan (
        .clock     (clock),
        .reset     (reset),
        .i_req     (irq_req[g]),
        .i_clr     (w_clr[g]),
        .o_pending (w_pending[g])
      );
    end
  endgenerate

  always_comb begin
    w_low = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_elig[i]) w_low = CH_W'(i);
  end

  always_comb begin
    w_state_n  = r_state;
    w_irq_n    = r_irq;
    w_vector_n = r_vector;
    w_ack_clr  = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_elig) begin
          w_vector_n = w_low;
          w_irq_n    = 1'b1;
          w_state_n  = S_ASSERT;
        end
      end
      S_ASSERT: begin
        // Committed: mask changes or W1C do not withdraw irq, only ack does.
        if (irq_ack) begin
          for (int i = 0; i < NUM_CH; i++)
            w_ack_clr[i] = (r_vector == CH_W'(i));
          w_irq_n   = 1'b0;
          w_state_n = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (w_eoi) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata_n = '0;
    if (w_roff[15:2] == 14'd0) begin
      case (w_roff[1:0])
        2'd0:    w_rdata_n[NUM_CH-1:0] = r_mask;
        2'd1:    w_rdata_n[NUM_CH-1:0] = w_pending;
        2'd2:    w_rdata_n[CH_W+1:0]   = {w_busy, r_irq, r_vector};
        default: w_rdata_n = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_irq    <= 1'b0;
      r_vector <= '0;
      r_mask   <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_irq    <= w_irq_n;
      r_vector <= w_vector_n;
      r_rdata  <= w_rdata_n;
      if (w_mask_we) r_mask <= wdata[NUM_CH-1:0];
    end
  end

  assign irq    = r_irq;
  assign vector = r_vector;
  assign busy   = w_busy;
  assign rdata  = r_rdata;
endmodule

// File: tb/tb_io_irq_controller.sv
// Scoreboard bench: the stimulus side runs a behavioural model and queues the expected
// outputs of every cycle; a monitor pops and compares them after each rising edge.

module tb_io_irq_controller;
  localparam int          N    = 4;
  localparam int          CW   = 2;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] A_MASK = BASE, A_PEND = BASE + 16'd1;
  localparam logic [15:0] A_STAT = BASE + 16'd2, A_EOI = BASE + 16'd3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  irq_req = '0;
  logic          irq_ack = 1'b0;
  logic          irq, busy;
  logic [CW-1:0] vector;
  logic [15:0]   waddr = '0, wdata = '0, raddr = '0, rdata;
  logic          wenable = 1'b0;

  io_irq_controller #(.NUM_CH(N), .CH_W(CW), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .irq_req(irq_req), .irq_ack(irq_ack),
    .irq(irq), .vector(vector), .busy(busy),
    .waddr(waddr), .wdata(wdata), .wenable(wenable),
    .raddr(raddr), .rdata(rdata)
  );

  always #5 clock = ~clock;

  typedef struct {int irq; int vec; int busy; int rdata;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, pushed = 0, popped = 0;

  // Model state: phase 0 = waiting, 1 = request raised to CPU, 2 = being serviced.
  int m_mask, m_pend, m_prev, m_phase, m_irq, m_vec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int offset(input logic [15:0] a);
    return (int'(a) - int'(BASE)) & 'hFFFF;
  endfunction

  function automatic int reg_read(input logic [15:0] a);
    case (offset(a))
      0: return m_mask;
      1: return m_pend;
      2: return ((m_phase != 0) ? (1 << (CW + 1)) : 0) + (m_irq << CW) + m_vec;
      default: return 0;
    endcase
  endfunction

  function automatic void model_clear();
    m_mask = 0; m_pend = 0; m_prev = 0; m_phase = 0; m_irq = 0; m_vec = 0;
  endfunction

  task automatic cyc(input logic [N-1:0] rq, input logic ak, input logic we,
                     input logic [15:0] wa, input logic [15:0] wd, input logic [15:0] ra);
    exp_t e;
    int clr, new_mask, eoi, wo;
    @(negedge clock);
    irq_req = rq; irq_ack = ak; wenable = we; waddr = wa; wdata = wd; raddr = ra;
    e.rdata  = reg_read(ra);
    clr      = 0;
    eoi      = 0;
    new_mask = m_mask;
    wo       = offset(wa);
    if (we) begin
      if (wo == 0) new_mask = wd & 'hF;
      if (wo == 1) clr = wd & 'hF;
      if (wo == 3) eoi = 1;
    end
    if (m_phase == 0) begin
      if ((m_pend & m_mask) != 0) begin
        for (int i = 0; i < N; i++)
          if (((m_pend & m_mask) >> i) & 1) begin m_vec = i; break; end
        m_irq = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ak) begin clr = clr | (1 << m_vec); m_irq = 0; m_phase = 2; end
    end else if (eoi) begin
      m_phase = 0;
    end
    m_pend = (m_pend & ~clr) | (int'(rq) & ~m_prev & 'hF);
    m_prev = int'(rq);
    m_mask = new_mask;
    e.irq = m_irq; e.vec = m_vec; e.busy = (m_phase != 0); e.rdata = e.rdata;
    q.push_back(e);
    pushed++;
  endtask

  task automatic nop(input logic [N-1:0] rq, input logic [15:0] ra);
    cyc(rq, 1'b0, 1'b0, 16'h0, 16'h0, ra);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [N-1:0] rq);
    cyc(rq, 1'b0, 1'b1, a, d, A_STAT);
  endtask

  task automatic ack(input logic [N-1:0] rq);
    cyc(rq, 1'b1, 1'b0, 16'h0, 16'h0, A_PEND);
  endtask

  // Reset lands between edges so the asynchronous clear is observable before any edge.
  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    irq_req = '0; irq_ack = 1'b0; wenable = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    #1;
    chk("rst_irq", irq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vector", vector, 0);
    chk("rst_rdata", rdata, 0);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      popped++;
      chk("irq", irq, e.irq);
      chk("vector", vector, e.vec);
      chk("busy", busy, e.busy);
      chk("rdata", rdata, e.rdata);
    end
  end

  initial begin
    logic [N-1:0] rq;
    logic [15:0]  wa, ra;
    model_clear();
    do_reset();

    // Single pulse on channel 2 with everything unmasked.
    wr(A_MASK, 16'h000F, 4'h0);
    nop(4'h4, A_PEND);
    nop(4'h0, A_PEND);
    nop(4'h0, A_STAT);
    nop(4'h0, A_STAT);
    ack(4'h0);
    wr(A_EOI, 16'h0, 4'h0);
    nop(4'h0, A_STAT);

    // Channels 3 and 1 together: 1 first, 3 after EOI.
    nop(4'hA, A_PEND);
    nop(4'h0, A_STAT);
    nop(4'h0, A_STAT);
    ack(4'h0);
    nop(4'h0, A_PEND);
    wr(A_EOI, 16'h0, 4'h0);
    nop(4'h0, A_STAT);
    nop(4'h0, A_STAT);
    nop(4'h0, A_STAT);
    ack(4'h0);
    wr(A_EOI, 16'h0, 4'h0);

    // Masked pending, then unmask.
    wr(A_MASK, 16'h0000, 4'h0);
    nop(4'h1, A_PEND);
    nop(4'h0, A_PEND);
    nop(4'h0, A_STAT);
    wr(A_MASK, 16'h0001, 4'h0);
    nop(4'h0, A_STAT);
    nop(4'h0, A_STAT);

    // Ack together with a new rise on the asserted channel.
    cyc(4'h1, 1'b1, 1'b0, 16'h0, 16'h0, A_PEND);
    nop(4'h0, A_PEND);
    nop(4'h0, A_STAT);
    wr(A_EOI, 16'h0, 4'h0);
    nop(4'h0, A_STAT);
    ack(4'h0);
    wr(A_EOI, 16'h0, 4'h0);

    // Held level, W1C of the committed channel, no second request.
    wr(A_MASK, 16'h0002, 4'h0);
    for (int i = 0; i < 10; i++) nop(4'h2, A_PEND);
    wr(A_PEND, 16'h0002, 4'h2);
    nop(4'h2, A_STAT);
    ack(4'h2);
    wr(A_EOI, 16'h0, 4'h0);
    for (int i = 0; i < 4; i++) nop(4'h0, A_STAT);

    // Reset during service, then an EOI that must do nothing.
    wr(A_MASK, 16'h000F, 4'h0);
    nop(4'h8, A_STAT);
    nop(4'h0, A_STAT);
    nop(4'h0, A_STAT);
    ack(4'h0);
    nop(4'h0, A_STAT);
    do_reset();
    nop(4'h0, A_MASK);
    wr(A_EOI, 16'h0, 4'h0);
    nop(4'h0, A_PEND);
    nop(4'h0, A_STAT);

    // Randomized traffic, including out-of-window addresses and periodic resets.
    rq = '0;
    for (int i = 0; i < 800; i++) begin
      rq = rq ^ (N'($urandom) & N'($urandom));
      wa = 16'(BASE + 16'($urandom_range(0, 5)) - 16'd1);
      ra = 16'(BASE + 16'($urandom_range(0, 5)) - 16'd1);
      cyc(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          wa, 16'($urandom), ra);
      if (i % 250 == 249) begin
        do_reset();
        rq = '0;
      end
    end

    @(posedge clock);
    #3;
    chk("drain", popped, pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/io_irq_controller.md
Name: io_irq_controller

Overview:
- Parametrised interrupt and I/O-status hub that merges the irq lines of up to NUM_CH io_interface peripherals (keyboard, VGA, future devices) into the single CPU irq / reset_irq pair.
- Provides per-channel edge capture, mask, fixed priority, a latched vector, and end-of-interrupt (EOI) sequencing, none of which a single shared irq wire supports.
- Sits between the peripheral drivers and the datapath's irq/reset_irq.
- Exposes a small memory-mapped register window on the same 16-bit waddr/raddr/wdata/rdata/wenable bus shape used by io_interface.

Parameters:
- NUM_CH, 4, number of interrupt channels, 1..16.
- CH_W, 2, vector width, must equal max(1, ceil(log2(NUM_CH))).
- BASE_ADDR, 16'hFF00, word address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_req  in  NUM_CH  per-channel request level from the peripherals; sampled only on rising edges.
- irq_ack  in  1  CPU acknowledge (the datapath's reset_irq); one-cycle pulse.
- irq  out  1  interrupt request to the CPU.
- vector  out  CH_W  index of the channel currently asserted or in service.
- busy  out  1  high in ASSERT and SERVICE.
- waddr  in  16  register write address.
- wdata  in  16  register write data.
- wenable  in  1  write strobe; one write per asserted cycle.
- raddr  in  16  register read address.
- rdata  out  16  registered read data.

Behaviour:
- Reset (asynchronous, active-high) clears everything:
  - irq=0, vector=0, busy=0, rdata=0.
  - mask=0, pending=0, edge history=0, state=IDLE.
- Edge capture:
  - prev[i] <= irq_req[i] every cycle.
  - A rise (irq_req[i] & ~prev[i]) sets pending[i] on the next edge.
  - A level held high does not re-trigger.
- Register map (offset from BASE_ADDR):
  - 0 MASK: read/write, low NUM_CH bits; channel i is eligible when mask[i]=1.
  - 1 PENDING: read; writing 1 to a bit clears it (W1C).
  - 2 STATUS: read {busy, irq, vector} in bits [CH_W+1:0]; writes are ignored.
  - 3 EOI: any write ends service; reads return 0.
- Bus rules:
  - Unused upper bits read 0.
  - Addresses outside the window: writes are ignored and rdata<=0.
  - Read latency is 1 cycle: rdata reflects the register values from before any write in the same cycle.
- State machine:
  - IDLE: if (pending & mask)!=0, vector<=lowest set index (index 0 has highest priority), irq<=1, go to ASSERT. Otherwise stay.
  - ASSERT: irq holds at 1 and vector is frozen. On irq_ack: clear pending[vector], irq<=0, go to SERVICE. Clearing the mask bit of the asserted channel while in ASSERT does not withdraw irq; the request is committed.
  - SERVICE: irq=0 and vector is held. Any write to EOI returns to IDLE. No nesting; new pendings wait.
- Simultaneous events:
  - A rise on channel i in the same cycle its pending bit is cleared (by ack or W1C): the set wins and pending[i] stays 1.
  - A W1C of pending[vector] while in ASSERT: irq stays asserted until ack.
  - An EOI write in IDLE or ASSERT is ignored.
  - irq_ack outside ASSERT is ignored.
  - When EOI returns to IDLE with other pendings eligible, irq re-asserts on the cycle after IDLE is entered (2 cycles after the EOI write).
- Latency: a rise on an eligible channel while IDLE gives pending=1 after 1 edge and irq=1 after 2 edges.
- A reset mid-operation aborts service immediately; no pending state survives.

Test Plan:
- Reset, write MASK=0xF, pulse irq_req[2] for 1 cycle -> pending=0x4 next cycle, irq=1 and vector=2 one cycle later, STATUS reads {1,1,2}.
- Set pending on channels 3 and 1 in the same cycle -> vector=1 first. Then ack -> PENDING reads 0x8. Then EOI write -> irq re-asserts with vector=3 two cycles after EOI.
- MASK=0x0, rise on channel 0 -> PENDING=0x1 and irq stays 0. Write MASK=0x1 -> irq=1 next IDLE cycle with vector=0.
- In ASSERT on channel 0, pulse irq_ack in the same cycle as a new rise on irq_req[0] -> PENDING bit 0 remains 1 and state becomes SERVICE.
- Hold irq_req[1] high for 10 cycles with MASK=0x2 -> exactly one pending set. W1C write 0x2 -> PENDING=0, and no second irq follows after ack and EOI.
- Assert reset during SERVICE -> irq, busy, vector, MASK and PENDING are all 0 asynchronously. An EOI write afterward has no effect.
